multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main sequencing controller for the multicycle datapath: one FSM that drives every datapath control input from `Instr` and `ALUFlags`.
- Owns a registered NZCV flags register and evaluates the condition field of each instruction.
- Sequences fetch, decode, execute, memory and writeback, including two-cycle long-multiply writeback and the FPU path.
- Sits beside the datapath at the CPU top level; `MemWrite` goes to the memory.

Parameters:
- `RESET_STATE`, 4'd0: FSM state entered on reset (FETCH).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `Instr`  in  32  current instruction register
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU, combinational
- `PCWrite`, `RegWrite`, `IRWrite`, `AdrSrc`, `MemWrite`  out  1 each  datapath/memory strobes
- `RegSrc`, `ALUSrcA`, `ALUSrcB`, `ResultSrc`, `ImmSrc`  out  2 each  mux selects
- `ALUControl`  out  4  ALU op
- `FPUOp`  out  2  FPU op; 2'b10 means ALU path selected
- `PCS`, `WAsel`, `ResultWEn`, `AandBWrite`, `RA2Sel`  out  1 each
- `Flags`  out  4  registered NZCV
- `State`  out  4  current FSM state (debug)

Behaviour:
- Decode fields:
  - Op = `Instr[27:26]`, I = `Instr[25]`, cmd = `Instr[24:21]`, S = `Instr[20]`, cond = `Instr[31:28]`.
  - MUL class: Op=00, I=0, `Instr[7:4]`=1001. `Instr[23]`=0 is MUL; `Instr[23:22]`=10 is UMULL; 11 is SMULL.
  - Op=01 is LDR/STR; `Instr[20]`=1 means load.
  - Op=10 is B.
  - Op=11 is FP: `Instr[20]`=0 is FADD, 1 is FMUL.
- ALUControl map:
  - ADD (cmd 0100) → 0010; SUB (0010) → 0011; CMP (1010) → 0011 with no register write; AND (0000) → 0110; ORR (1100) → 0111.
  - MUL → 0000; UMULL → 0100; SMULL → 0101.
  - Any other cmd → 0010.
- Condition codes:
  - 1110 AL; 0000 EQ (Z); 0001 NE (!Z); 1010 GE (N==V); 1011 LT (N!=V).
  - Any other cond is treated as AL.
  - Evaluated on the registered Flags.
- State encoding:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXECR, 7 EXECI, 8 ALUWB, 9 BRANCH, 10 EXECFP, 11 LWB_LO, 12 LWB_HI.
  - Undefined encodings go to FETCH next cycle.
- Defaults: every strobe is 0 in every state unless listed below; FPUOp=10; selects are 0.
- Decoded in every state: RegSrc[0] = (Op==10), RegSrc[1] = (Op==01 & store), ImmSrc = Op.
- Per-state outputs and next state:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ALUControl=0010, PCWrite=1. Next: DECODE.
  - DECODE: AandBWrite=1; RA2Sel=1 for stores.
    - Condition fails → FETCH, with no other side effects in any later cycle.
    - Otherwise: MEMADR (Op 01), BRANCH (Op 10), EXECFP (Op 11), EXECR (MUL class or I=0), EXECI (I=1).
  - MEMADR: ALUSrcB=01, ALUControl=0010, ResultWEn=1. Next: MEMRD if load, else MEMWR.
  - MEMRD: AdrSrc=1, ALUSrcB=01, ALUControl=0010. Next: MEMWB.
  - MEMWR: same as MEMRD plus MemWrite=1. Next: FETCH.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - EXECR / EXECI: ALUSrcB=00 (EXECR) or 01 (EXECI); ALUControl per map; ResultWEn=1.
    - Flags ← ALUFlags at the clock edge if S=1 or CMP.
    - Next: LWB_LO if UMULL/SMULL; FETCH if CMP; else ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, WAsel=0. Next: FETCH.
  - LWB_LO: ResultSrc=10, RegWrite=1, WAsel=0 (Rd = `Instr[15:12]`). Next: LWB_HI.
  - LWB_HI: ResultSrc=11, RegWrite=1, WAsel=1 (`Instr[19:16]`). Next: FETCH.
  - EXECFP: FPUOp = {1'b0, `Instr[20]`}, ResultWEn=1. Next: ALUWB. Flags unaffected.
  - BRANCH: ALUSrcA=01, ALUSrcB=01, ALUControl=0010, PCWrite=1, PCS=1. Next: FETCH.
- Latencies (cycles): branch 3; data-processing 4; CMP 3; load 5; store 4; long multiply 5; FP 4.
- Reset (asynchronous, mid-operation included):
  - State ← FETCH and Flags ← 0000 immediately.
  - All outputs take their FETCH values while reset is held.
  - No RegWrite or MemWrite pulse may be produced from an interrupted instruction.
- Flags write and FETCH never coincide; each flag update is exactly one edge.

Test Plan:
- Reset during MEMWR (assert reset mid-cycle) → State=0, MemWrite=0 that same cycle; Flags=0000.
- ADD, I=1, S=1, operands 5+(−5) → state sequence 0,1,7,8,0; Flags=0100 after EXECI; exactly one RegWrite pulse, in ALUWB.
- BEQ executed with Z=0 → DECODE→FETCH with no PCS/PCWrite in between. Repeat with Z=1 → BRANCH asserts PCWrite=PCS=1 for one cycle.
- SMULL → ALUControl=0101 in EXECR; LWB_LO has ResultSrc=10, WAsel=0; LWB_HI has ResultSrc=11, WAsel=1; exactly 2 RegWrite pulses.
- LDR then STR back-to-back → LDR sequence 0,1,2,3,4; STR sequence 0,1,2,5 with AdrSrc=1 and RA2Sel=1 in DECODE; MemWrite high exactly one cycle.
- FMUL → FPUOp=01 in EXECFP only, 10 in all other cycles; Flags unchanged; CMP → no RegWrite and returns to FETCH after EXECR.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main sequencing controller for the multicycle datapath. One FSM steps each
//   instruction through fetch, decode, execute, memory and writeback. The block
//   also holds the registered NZCV flags that condition-code evaluation uses.
//
// Ports
//   clk, reset      clock and asynchronous active-high reset
//   Instr[31:0]     current instruction register
//   ALUFlags[3:0]   {N,Z,C,V} from the ALU (combinational)
//   PCWrite, RegWrite, IRWrite, AdrSrc, MemWrite     datapath/memory strobes
//   RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc      2-bit mux selects
//   ALUControl[3:0] ALU operation
//   FPUOp[1:0]      FPU operation, 2'b10 selects the ALU path
//   PCS, WAsel, ResultWEn, AandBWrite, RA2Sel         misc datapath controls
//   Flags[3:0]      registered NZCV
//   State[3:0]      current FSM state (debug)
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic [1:0]  FPUOp,
    output logic        PCS,
    output logic        WAsel,
    output logic        ResultWEn,
    output logic        AandBWrite,
    output logic        RA2Sel,
    output logic [3:0]  Flags,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        EXECFP = 4'd10,
        LWB_LO = 4'd11,
        LWB_HI = 4'd12
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [1:0]  op;
    logic        i_bit;
    logic [3:0]  cmd;
    logic        s_bit;
    logic [3:0]  cond;
    logic        is_mul;
    logic        is_long_mul;
    logic        is_cmp;
    logic        is_load;
    logic        cond_ok;
    logic        flags_we;
    logic [3:0]  alu_ctrl_dec;
    logic        unused_instr_bits;

    assign op      = Instr[27:26];
    assign i_bit   = Instr[25];
    assign cmd     = Instr[24:21];
    assign s_bit   = Instr[20];
    assign cond    = Instr[31:28];
    assign is_load = Instr[20];

    // Register fields are consumed by the datapath, not by this controller.
    assign unused_instr_bits = &{1'b0, Instr[19:8], Instr[3:0]};

    // The multiply class overlaps the data-processing encoding space, so it
    // is recognised first and CMP is only decoded outside of it.
    assign is_mul      = (op == 2'b00) && !i_bit && (Instr[7:4] == 4'b1001);
    assign is_long_mul = is_mul && Instr[23];
    assign is_cmp      = !is_mul && (op == 2'b00) && (cmd == 4'b1010);

    always_comb begin
        alu_ctrl_dec = 4'b0010;
        if (is_mul) begin
            if (!Instr[23])
                alu_ctrl_dec = 4'b0000;
            else if (Instr[22])
                alu_ctrl_dec = 4'b0101;
            else
                alu_ctrl_dec = 4'b0100;
        end else begin
            case (cmd)
                4'b0100: alu_ctrl_dec = 4'b0010;
                4'b0010: alu_ctrl_dec = 4'b0011;
                4'b1010: alu_ctrl_dec = 4'b0011;
                4'b0000: alu_ctrl_dec = 4'b0110;
                4'b1100: alu_ctrl_dec = 4'b0111;
                default: alu_ctrl_dec = 4'b0010;
            endcase
        end
    end

    // Condition check uses the registered flags; Flags = {N,Z,C,V}.
    always_comb begin
        cond_ok = 1'b1;
        case (cond)
            4'b0000: cond_ok = Flags[2];
            4'b0001: cond_ok = !Flags[2];
            4'b1010: cond_ok = (Flags[3] == Flags[0]);
            4'b1011: cond_ok = (Flags[3] != Flags[0]);
            default: cond_ok = 1'b1;
        endcase
    end

    assign flags_we = ((state == EXECR) || (state == EXECI)) && (s_bit || is_cmp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= state_t'(RESET_STATE);
        else
            state <= next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            Flags <= 4'b0000;
        else if (flags_we)
            Flags <= ALUFlags;
    end

    assign State     = state;
    assign RegSrc[0] = (op == 2'b10);
    assign RegSrc[1] = (op == 2'b01) && !is_load;
    assign ImmSrc    = op;

    always_comb begin
        next_state = FETCH;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 4'b0000;
        FPUOp      = 2'b10;
        PCS        = 1'b0;
        WAsel      = 1'b0;
        ResultWEn  = 1'b0;
        AandBWrite = 1'b0;
        RA2Sel     = 1'b0;

        case (state)
            FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ALUControl = 4'b0010;
                PCWrite    = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                AandBWrite = 1'b1;
                RA2Sel     = (op == 2'b01) && !is_load;
                // A failed condition retires the instruction here with no
                // further side effects.
                if (!cond_ok)
                    next_state = FETCH;
                else if (op == 2'b01)
                    next_state = MEMADR;
                else if (op == 2'b10)
                    next_state = BRANCH;
                else if (op == 2'b11)
                    next_state = EXECFP;
                else if (is_mul || !i_bit)
                    next_state = EXECR;
                else
                    next_state = EXECI;
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = 4'b0010;
                ResultWEn  = 1'b1;
                next_state = is_load ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc     = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = 4'b0010;
                next_state = MEMWB;
            end
            MEMWR: begin
                AdrSrc     = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = 4'b0010;
                MemWrite   = 1'b1;
                next_state = FETCH;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_ctrl_dec;
                ResultWEn  = 1'b1;
                if (is_long_mul)
                    next_state = LWB_LO;
                else if (is_cmp)
                    next_state = FETCH;
                else
                    next_state = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            LWB_LO: begin
                ResultSrc  = 2'b10;
                RegWrite   = 1'b1;
                next_state = LWB_HI;
            end
            LWB_HI: begin
                ResultSrc  = 2'b11;
                RegWrite   = 1'b1;
                WAsel      = 1'b1;
                next_state = FETCH;
            end
            EXECFP: begin
                FPUOp      = {1'b0, Instr[20]};
                ResultWEn  = 1'b1;
                next_state = ALUWB;
            end
            BRANCH: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ALUControl = 4'b0010;
                PCWrite    = 1'b1;
                PCS        = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. Each instruction is held on Instr while
//   the controller steps through it; one snapshot per cycle is taken mid-cycle
//   and compared against hand-derived state sequences and strobe patterns.
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, RegWrite, IRWrite, AdrSrc, MemWrite;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [3:0]  ALUControl;
    logic [1:0]  FPUOp;
    logic        PCS, WAsel, ResultWEn, AandBWrite, RA2Sel;
    logic [3:0]  Flags;
    logic [3:0]  State;

    int total_checks;
    int bad_checks;

    logic [31:0] seq;
    int          cnt_regwrite;
    int          cnt_memwrite;
    int          cnt_pcwrite;
    int          cnt_pcs;
    int          cnt_fpu;
    logic        cap_regwrite [8];
    logic        cap_adrsrc   [8];
    logic        cap_ra2sel   [8];
    logic        cap_pcs      [8];
    logic        cap_wasel    [8];
    logic [1:0]  cap_resultsrc[8];
    logic [1:0]  cap_fpuop    [8];
    logic [3:0]  cap_aluctrl  [8];

    localparam logic [31:0] I_ADDS  = 32'hE291_0005;
    localparam logic [31:0] I_CMP   = 32'hE151_0002;
    localparam logic [31:0] I_BEQ   = 32'h0A00_0010;
    localparam logic [31:0] I_SMULL = 32'hE0C3_2190;
    localparam logic [31:0] I_LDR   = 32'hE591_2000;
    localparam logic [31:0] I_STR   = 32'hE581_2000;
    localparam logic [31:0] I_FMUL  = 32'hEC10_0000;

    multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .FPUOp      (FPUOp),
        .PCS        (PCS),
        .WAsel      (WAsel),
        .ResultWEn  (ResultWEn),
        .AandBWrite (AandBWrite),
        .RA2Sel     (RA2Sel),
        .Flags      (Flags),
        .State      (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Entered in the low clock phase while the DUT sits in FETCH; records one
    // snapshot per cycle for ncyc cycles and then checks the state reached.
    task automatic applyStimulus(input string tag, input logic [31:0] instr,
                                 input logic [3:0] alu_flags, input int ncyc,
                                 input logic [3:0] end_state);
        Instr        = instr;
        ALUFlags     = alu_flags;
        seq          = 32'h0;
        cnt_regwrite = 0;
        cnt_memwrite = 0;
        cnt_pcwrite  = 0;
        cnt_pcs      = 0;
        cnt_fpu      = 0;
        for (int c = 0; c < ncyc; c++) begin
            #1;
            seq              = (seq << 4) | {28'h0, State};
            cap_regwrite[c]  = RegWrite;
            cap_adrsrc[c]    = AdrSrc;
            cap_ra2sel[c]    = RA2Sel;
            cap_pcs[c]       = PCS;
            cap_wasel[c]     = WAsel;
            cap_resultsrc[c] = ResultSrc;
            cap_fpuop[c]     = FPUOp;
            cap_aluctrl[c]   = ALUControl;
            if (RegWrite)           cnt_regwrite++;
            if (MemWrite)           cnt_memwrite++;
            if (c > 0 && PCWrite)   cnt_pcwrite++;
            if (PCS)                cnt_pcs++;
            if (FPUOp != 2'b10)     cnt_fpu++;
            @(negedge clk);
        end
        #1;
        checkOutput({tag, "_end_state"}, {28'h0, State}, {28'h0, end_state});
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        reset        = 1'b1;
        Instr        = 32'h0;
        ALUFlags     = 4'b0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_state",   {28'h0, State}, 32'h0);
        checkOutput("rst_flags",   {28'h0, Flags}, 32'h0);
        checkOutput("rst_irwrite", {31'h0, IRWrite}, 32'h1);
        checkOutput("rst_pcwrite", {31'h0, PCWrite}, 32'h1);
        @(negedge clk);
        reset = 1'b0;

        // CMP loads flags from the ALU, never writes a register.
        applyStimulus("cmp", I_CMP, 4'b1001, 3, 4'd0);
        checkOutput("cmp_seq",      seq, 32'h016);
        checkOutput("cmp_regwrite", cnt_regwrite, 32'd0);
        checkOutput("cmp_flags",    {28'h0, Flags}, 32'h9);

        // STR interrupted by reset while MemWrite is high.
        applyStimulus("str_rst", I_STR, 4'b0000, 3, 4'd5);
        #1;
        checkOutput("str_rst_memwr_pre", {31'h0, MemWrite}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("str_rst_state",    {28'h0, State}, 32'h0);
        checkOutput("str_rst_memwrite", {31'h0, MemWrite}, 32'h0);
        checkOutput("str_rst_flags",    {28'h0, Flags}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("str_rst_hold_memwrite", {31'h0, MemWrite}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // BEQ with Z=0 retires from DECODE.
        applyStimulus("beq_nt", I_BEQ, 4'b0100, 2, 4'd0);
        checkOutput("beq_nt_seq",     seq, 32'h01);
        checkOutput("beq_nt_pcwrite", cnt_pcwrite, 32'd0);
        checkOutput("beq_nt_pcs",     cnt_pcs, 32'd0);

        // ADDS immediate producing zero.
        applyStimulus("adds", I_ADDS, 4'b0100, 4, 4'd0);
        checkOutput("adds_seq",      seq, 32'h0178);
        checkOutput("adds_flags",    {28'h0, Flags}, 32'h4);
        checkOutput("adds_regwrite", cnt_regwrite, 32'd1);
        checkOutput("adds_rw_aluwb", {31'h0, cap_regwrite[3]}, 32'h1);

        // BEQ with Z=1 takes the branch.
        applyStimulus("beq_t", I_BEQ, 4'b0000, 3, 4'd0);
        checkOutput("beq_t_seq",     seq, 32'h019);
        checkOutput("beq_t_pcwrite", cnt_pcwrite, 32'd1);
        checkOutput("beq_t_pcs",     cnt_pcs, 32'd1);
        checkOutput("beq_t_pcs_br",  {31'h0, cap_pcs[2]}, 32'h1);

        // SMULL with two-cycle writeback; S=0 so flags hold.
        applyStimulus("smull", I_SMULL, 4'b1111, 5, 4'd0);
        checkOutput("smull_seq",      seq, 32'h016BC);
        checkOutput("smull_aluctrl",  {28'h0, cap_aluctrl[2]}, 32'h5);
        checkOutput("smull_lo_rsrc",  {30'h0, cap_resultsrc[3]}, 32'h2);
        checkOutput("smull_lo_wasel", {31'h0, cap_wasel[3]}, 32'h0);
        checkOutput("smull_hi_rsrc",  {30'h0, cap_resultsrc[4]}, 32'h3);
        checkOutput("smull_hi_wasel", {31'h0, cap_wasel[4]}, 32'h1);
        checkOutput("smull_regwrite", cnt_regwrite, 32'd2);
        checkOutput("smull_flags",    {28'h0, Flags}, 32'h4);

        // LDR then STR back to back.
        applyStimulus("ldr", I_LDR, 4'b0000, 5, 4'd0);
        checkOutput("ldr_seq",      seq, 32'h01234);
        checkOutput("ldr_memwrite", cnt_memwrite, 32'd0);
        checkOutput("ldr_rw_memwb", {31'h0, cap_regwrite[4]}, 32'h1);
        checkOutput("ldr_ra2sel",   {31'h0, cap_ra2sel[1]}, 32'h0);

        applyStimulus("str", I_STR, 4'b0000, 4, 4'd0);
        checkOutput("str_seq",      seq, 32'h0125);
        checkOutput("str_adrsrc",   {31'h0, cap_adrsrc[3]}, 32'h1);
        checkOutput("str_ra2sel",   {31'h0, cap_ra2sel[1]}, 32'h1);
        checkOutput("str_memwrite", cnt_memwrite, 32'd1);
        checkOutput("str_regwrite", cnt_regwrite, 32'd0);

        // FMUL drives the FPU only in EXECFP and leaves flags alone.
        applyStimulus("fmul", I_FMUL, 4'b1111, 4, 4'd0);
        checkOutput("fmul_seq",      seq, 32'h01A8);
        checkOutput("fmul_fpuop",    {30'h0, cap_fpuop[2]}, 32'h1);
        checkOutput("fmul_fpu_cnt",  cnt_fpu, 32'd1);
        checkOutput("fmul_flags",    {28'h0, Flags}, 32'h4);
        checkOutput("fmul_regwrite", cnt_regwrite, 32'd1);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
